// File: rtl/pwm_spi_config_ctrl.sv
// pwm_spi_config_ctrl
// SPI-slave (mode 0) configuration front end for the multi-channel PWM driver.
// 8-bit command frames stage per-channel duty values in shadow registers.
// Staged values reach duty_o only on period_start, so a channel never changes
// mid-period.
// Optional build macro: PWM_SPI_READBACK_EN adds a status byte shifted out on
// spi_miso during each frame. Without it, spi_miso is tied low.
//
// state | meaning
// IDLE  | waiting for synchronised cs_n to fall
// SHIFT | capturing command bits on synchronised sclk rising edges
// DONE  | one clk to decode the captured frame
// WAIT  | frame consumed; sclk ignored until cs_n rises
module pwm_spi_config_ctrl #(
  parameter int NUM_CH = 7,
  parameter int DUTY_W = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     spi_sclk,
  input  logic                     spi_cs_n,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  input  logic                     period_start,
  output logic [NUM_CH*DUTY_W-1:0] duty_o,
  output logic [NUM_CH-1:0]        pending_o,
  output logic                     commit_o,
  output logic                     frame_err_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT} state_t;

  state_t            state;
  logic              sclk_s1, sclk_s2, sclk_d;
  logic              cs_s1, cs_s2, cs_d;
  logic              mosi_s1, mosi_s2;
  logic              sclk_rise, cs_fall, cs_rise;
  logic [3:0]        bit_cnt;
  logic [7:0]        frame_sr;
  logic [2:0]        last_ch;
  logic [DUTY_W-1:0] shadow [NUM_CH];
  logic [DUTY_W-1:0] duty_q [NUM_CH];

  logic              f_wr;
  logic [2:0]        f_ch;
  logic [DUTY_W-1:0] f_duty;
  logic              ch_ok;

  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign cs_fall   = ~cs_s2 & cs_d;
  assign cs_rise   = cs_s2 & ~cs_d;

  assign f_wr   = frame_sr[7];
  assign f_ch   = frame_sr[6:4];
  assign f_duty = frame_sr[DUTY_W-1:0];
  assign ch_ok  = (int'(f_ch) < NUM_CH);

  // Two-flop synchronisers for the SPI pins plus one delay stage for edge detect
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_d    <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= spi_sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      cs_s1   <= spi_cs_n;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      mosi_s1 <= spi_mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  // Frame FSM, decode into shadows, and period-boundary commit of shadows
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      frame_sr    <= '0;
      last_ch     <= '0;
      pending_o   <= '0;
      commit_o    <= 1'b0;
      frame_err_o <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= '0;
        duty_q[i] <= '0;
      end
    end else begin
      // Commit sees pre-decode shadows; a same-cycle decode re-sets pending below.
      commit_o <= period_start && (pending_o != '0);
      if (period_start) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (pending_o[i]) begin
            duty_q[i]    <= shadow[i];
            pending_o[i] <= 1'b0;
          end
        end
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state       <= IDLE;
            frame_err_o <= 1'b1;
          end else if (sclk_rise) begin
            frame_sr <= {frame_sr[6:0], mosi_s2};
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) state <= DONE;
          end
        end
        DONE: begin
          state <= WAIT;
          if (f_wr) begin
            if (f_ch == 3'd7) begin
              for (int i = 0; i < NUM_CH; i++) shadow[i] <= f_duty;
              pending_o <= '1;
            end else if (ch_ok) begin
              for (int i = 0; i < NUM_CH; i++) begin
                if (f_ch == 3'(i)) begin
                  shadow[i]    <= f_duty;
                  pending_o[i] <= 1'b1;
                end
              end
              last_ch <= f_ch;
            end else begin
              frame_err_o <= 1'b1;
            end
          end else begin
            if (f_ch == 3'd7) frame_err_o <= 1'b0;
            else              last_ch     <= f_ch;
          end
        end
        WAIT: begin
          // Level check: a cs_n rise that landed during DONE still releases us.
          if (cs_s2) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pack the committed duties onto the flat output bus
  always_comb begin
    duty_o = '0;
    for (int i = 0; i < NUM_CH; i++) duty_o[i*DUTY_W +: DUTY_W] = duty_q[i];
  end

  // Frame duty bits above DUTY_W are ignored by design
  generate
    if (DUTY_W < 4) begin : g_unused_duty
      logic unused_duty_bits;
      assign unused_duty_bits = ^frame_sr[3:DUTY_W];
    end
  endgenerate

`ifdef PWM_SPI_READBACK_EN
  logic       sclk_fall;
  logic [3:0] rb_duty;
  logic [7:0] status_sr;

  assign sclk_fall = ~sclk_s2 & sclk_d;

  // Committed duty of the last addressed channel, zero when out of range
  always_comb begin
    rb_duty = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (last_ch == 3'(i)) rb_duty[DUTY_W-1:0] = duty_q[i];
    end
  end

  // Status shifter: load at frame start, advance on sclk falling, zero-fill
  always_ff @(posedge clk) begin
    if (reset) begin
      status_sr <= '0;
    end else if (state == IDLE) begin
      if (cs_fall) status_sr <= {frame_err_o, last_ch, rb_duty};
      else         status_sr <= '0;
    end else if (sclk_fall) begin
      status_sr <= {status_sr[6:0], 1'b0};
    end
  end

  assign spi_miso = status_sr[7];
`else
  logic unused_last_ch;
  assign unused_last_ch = ^last_ch;
  assign spi_miso       = 1'b0;
`endif

endmodule

// File: doc/pwm_spi_config_ctrl.md
Name: pwm_spi_config_ctrl

Overview:
SPI-slave configuration controller for the multi-channel PWM driver. It receives 8-bit command frames over SPI and stages per-channel duty values in shadow registers. Staged values commit to the live duty outputs only on the PWM period boundary, so a channel never glitches mid-period. It sits between the chip IO pins and the PWM counter/compare datapath.

Parameters:
NUM_CH, 7, number of PWM channels (1..7)
DUTY_W, 3, duty width per channel in bits (1..4)

Ports:
clk  input  1  system clock
reset  input  1  reset
spi_sclk  input  1  SPI clock, asynchronous to clk, mode 0
spi_cs_n  input  1  SPI chip select, active-low, asynchronous
spi_mosi  input  1  SPI data in, MSB first
spi_miso  output  1  SPI data out
period_start  input  1  one-clk pulse from the PWM datapath at the start of each period
duty_o  output  NUM_CH*DUTY_W  committed duties; channel n occupies bits [n*DUTY_W +: DUTY_W]
pending_o  output  NUM_CH  per-channel flag: shadow value awaiting commit
commit_o  output  1  one-clk pulse when at least one channel committed
frame_err_o  output  1  sticky error flag

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high. Reset values: duty_o=0, shadows=0, pending_o=0, commit_o=0, frame_err_o=0, spi_miso=0, bit count=0, last_ch=0. Synchroniser flops reset to sclk=0, cs_n=1, mosi=0.
- Synchronisation: sclk, cs_n and mosi each pass through 2 flops. Edge detect is done on the synchronised sclk. A pin edge is acted on in the 3rd clk after it. clk must be at least 4x sclk.
- Frame states: IDLE -> SHIFT on synchronised cs_n falling; the bit count clears.
  - In SHIFT, each sclk rising edge shifts mosi into an 8-bit register.
  - At count 8 -> DONE; decode takes 1 clk, then -> WAIT.
  - WAIT ignores further sclk edges until cs_n rises, then -> IDLE.
  - cs_n rising in SHIFT with count < 8 -> IDLE. The frame is discarded and frame_err_o is set.
- Frame format: bit7 = write, bits[6:4] = channel, bits[3:0] = duty field. Only the low DUTY_W bits are used; the upper bits are ignored.
- Decode rules:
  - write=1, channel < NUM_CH: shadow[ch] <= duty, pending[ch] <= 1, last_ch <= ch.
  - write=1, channel = 7: broadcast. All shadows are written and all pending bits set; last_ch unchanged.
  - write=1, NUM_CH <= channel < 7: no register change; frame_err_o <= 1.
  - write=0, channel = 7: clear frame_err_o.
  - write=0, other channel: last_ch <= ch, with no register change (readback select).
- Commit: on period_start, for every channel with pending=1, duty <= shadow and pending <= 0. commit_o pulses 1 clk later, aligned with the duty_o update, only if any channel was pending.
- Simultaneous decode and period_start in the same clk: the commit uses the pre-decode shadow. The new write stays pending and commits at the next period_start.
- A rewrite of a pending channel before commit overwrites the shadow; only the last value commits.
- Reset mid-frame aborts the frame and returns to IDLE with all reset values; no partial write.

Optional Feature:
Macro PWM_SPI_READBACK_EN.
- Defined: on cs_n falling, load status = {frame_err_o, last_ch[2:0], duty[last_ch] zero-extended to 4 bits}. spi_miso drives the MSB, then shifts to the next bit on each synchronised sclk falling edge; it outputs 0 after 8 bits and in IDLE. If last_ch >= NUM_CH, the duty field reads 0.
- Undefined: spi_miso is tied 0 and no status register exists.

Test Plan:
- Write frame 0xA5 (ch2, duty 5) -> pending_o=0000100, duty_o unchanged. Pulse period_start -> ch2 duty=5, pending_o=0, commit_o high 1 clk.
- Broadcast 0xF3 then period_start -> all 7 channels = 3, pending cleared, single commit_o pulse.
- cs_n raised after 5 bits -> no shadow/pending change, frame_err_o=1. Then frame 0x70 -> frame_err_o=0.
- Frame 0x91 (ch1, duty 1) with decode in the same clk as period_start -> ch1 still old value, pending[1]=1. Next period_start -> ch1=1.
- Two writes to ch4 (duty 2, then 6) before period_start -> ch4 commits 6. With PWM_SPI_READBACK_EN, next frame's miso = 0x46.
- Assert reset after 4 bits of a frame -> all outputs zero, IDLE. A following full frame 0x87 -> ch0 pending with duty 7.
